// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the in-order pipeline result with queued long-latency results
// onto the single register-file write port, and flags registers still pending in the queue.
module wb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pipe_wreg,
   input  logic [ADDR_W-1:0]          pipe_wd,
   input  logic [DATA_W-1:0]          pipe_wdata,
   input  logic                       lu_valid,
   output logic                       lu_ready,
   input  logic [ADDR_W-1:0]          lu_waddr,
   input  logic [DATA_W-1:0]          lu_wdata,
   output logic                       we,
   output logic [ADDR_W-1:0]          waddr,
   output logic [DATA_W-1:0]          wdata,
   input  logic [ADDR_W-1:0]          chk_addr1,
   input  logic [ADDR_W-1:0]          chk_addr2,
   output logic                       chk_hit1,
   output logic                       chk_hit2,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;

   logic pipe_eff, pop, push;

   assign pipe_eff = pipe_wreg && (pipe_wd != '0);
   assign pop      = !pipe_eff && (count_q != '0);
   assign lu_ready = !rst && (count_q < CNT_W'(DEPTH));
   // Writes to r0 complete the handshake but are dropped.
   assign push     = lu_valid && lu_ready && (lu_waddr != '0);
   assign count    = count_q;

   always_comb begin
      vld_d   = vld_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop)  vld_d[rd_ptr_q] = 1'b0;
      if (push) vld_d[wr_ptr_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         addr_q[wr_ptr_q] <= lu_waddr;
         data_q[wr_ptr_q] <= lu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (pipe_eff) begin
         we    <= 1'b1;
         waddr <= pipe_wd;
         wdata <= pipe_wdata;
      end else if (pop) begin
         we    <= 1'b1;
         waddr <= addr_q[rd_ptr_q];
         wdata <= data_q[rd_ptr_q];
      end else begin
         we    <= 1'b0;
      end
   end

   // The output register is deliberately not checked: the regfile forwards its write data.
   always_comb begin
      chk_hit1 = 1'b0;
      chk_hit2 = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (vld_q[i] && (addr_q[i] == chk_addr1)) chk_hit1 = 1'b1;
         if (vld_q[i] && (addr_q[i] == chk_addr2)) chk_hit2 = 1'b1;
      end
      if (chk_addr1 == '0) chk_hit1 = 1'b0;
      if (chk_addr2 == '0) chk_hit2 = 1'b0;
   end

endmodule
